// File: rtl/hazard_ctrl_md_pkg.sv
// Shared constants and MDU decode for the D-stage hazard controller.
// Tuse/Tnew encodings, MDU timing defaults and the MDU instruction list.
package hazard_ctrl_md_pkg;

    localparam int TW = 2;
    localparam int AW = 5;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    localparam logic [TW-1:0] T0 = 2'd0;
    localparam logic [TW-1:0] T1 = 2'd1;
    localparam logic [TW-1:0] T2 = 2'd2;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    typedef enum logic [5:0] {
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1a,
        FN_DIVU  = 6'h1b
    } md_funct_e;

    // Decoder helper: D-stage instruction touches HI/LO or the MDU.
    function automatic logic is_md_instr(
        input logic [5:0] opcode,
        input logic [5:0] funct
    );
        logic hit;
        hit = 1'b0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: hit = 1'b1;
                default: hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_md_busy_ctr.sv
// MDU busy tracker: down-counter loaded on an MDU start.
// busy is high while an operation is still in flight.
module md_busy_ctr
    import hazard_ctrl_md_pkg::*;
#(
    parameter int CW       = 4,
    parameter int MULT_CYC = hazard_ctrl_md_pkg::MULT_CYC,
    parameter int DIV_CYC  = hazard_ctrl_md_pkg::DIV_CYC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_div,
    output logic          busy,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LD_MULT = CW'(MULT_CYC);
    localparam logic [CW-1:0] LD_DIV  = CW'(DIV_CYC);

    // Load on a start when idle, otherwise count down to zero and hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start && cnt == '0) begin
            cnt <= is_div ? LD_DIV : LD_MULT;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

    // A start while busy means the MDU stall failed upstream.
    a_no_start_busy: assert property (
        @(posedge clk) disable iff (reset) !(start && cnt != '0)
    ) else $error("md_busy_ctr: MDU start while busy ignored");

endmodule

// File: rtl/hazard_ctrl_md.sv
// D-stage hazard/stall controller: Tuse/Tnew register hazards,
// MDU busy interlock and a saturating stall-cycle counter.
module hazard_ctrl_md
    import hazard_ctrl_md_pkg::*;
#(
    parameter int TW       = hazard_ctrl_md_pkg::TW,
    parameter int AW       = hazard_ctrl_md_pkg::AW,
    parameter int MULT_CYC = hazard_ctrl_md_pkg::MULT_CYC,
    parameter int DIV_CYC  = hazard_ctrl_md_pkg::DIV_CYC,
    parameter int CW       = 4,
    parameter int PW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] Tuse_rs,
    input  logic [TW-1:0] Tuse_rt,
    input  logic [AW-1:0] D_rs_addr,
    input  logic [AW-1:0] D_rt_addr,
    input  logic [AW-1:0] E_RFDst,
    input  logic [TW-1:0] Tnew_E,
    input  logic [AW-1:0] M_RFDst,
    input  logic [TW-1:0] Tnew_M,
    input  logic          D_md_use,
    input  logic          E_md_start,
    input  logic          E_md_is_div,
    output logic          stall,
    output logic          md_busy,
    output logic [CW-1:0] md_cnt,
    output logic [PW-1:0] stall_cycles
);

    logic stall_rs_e;
    logic stall_rs_m;
    logic stall_rt_e;
    logic stall_rt_m;
    logic stall_md;

    md_busy_ctr #(
        .CW       (CW),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_is_div),
        .busy   (md_busy),
        .cnt    (md_cnt)
    );

    // Register hazards: operand needed before the producer delivers it.
    always_comb begin
        stall_rs_e = (Tuse_rs < Tnew_E) && (D_rs_addr != '0)
                  && (D_rs_addr == E_RFDst);
        stall_rs_m = (Tuse_rs < Tnew_M) && (D_rs_addr != '0)
                  && (D_rs_addr == M_RFDst);
        stall_rt_e = (Tuse_rt < Tnew_E) && (D_rt_addr != '0)
                  && (D_rt_addr == E_RFDst);
        stall_rt_m = (Tuse_rt < Tnew_M) && (D_rt_addr != '0)
                  && (D_rt_addr == M_RFDst);
        // The start cycle itself already blocks the next MDU instruction.
        stall_md   = D_md_use && (md_busy || E_md_start);
        stall      = stall_rs_e || stall_rs_m || stall_rt_e
                  || stall_rt_m || stall_md;
    end

    // Performance counter of stalled cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Directed bench for hazard_ctrl_md with a queue scoreboard.
// Expected values are queued when driven and checked at the negedge.
module tb_hazard_ctrl_md;

    localparam int TW = 2;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int PW = 4;

    logic          clk;
    logic          reset;
    logic [TW-1:0] Tuse_rs;
    logic [TW-1:0] Tuse_rt;
    logic [AW-1:0] D_rs_addr;
    logic [AW-1:0] D_rt_addr;
    logic [AW-1:0] E_RFDst;
    logic [TW-1:0] Tnew_E;
    logic [AW-1:0] M_RFDst;
    logic [TW-1:0] Tnew_M;
    logic          D_md_use;
    logic          E_md_start;
    logic          E_md_is_div;
    logic          stall;
    logic          md_busy;
    logic [CW-1:0] md_cnt;
    logic [PW-1:0] stall_cycles;

    typedef struct {
        string         tag;
        logic          stall;
        logic [CW-1:0] cnt;
        logic          busy;
        logic [PW-1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   sc_model;

    hazard_ctrl_md #(
        .TW       (TW),
        .AW       (AW),
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CW       (CW),
        .PW       (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Tuse_rs      (Tuse_rs),
        .Tuse_rt      (Tuse_rt),
        .D_rs_addr    (D_rs_addr),
        .D_rt_addr    (D_rt_addr),
        .E_RFDst      (E_RFDst),
        .Tnew_E       (Tnew_E),
        .M_RFDst      (M_RFDst),
        .Tnew_M       (Tnew_M),
        .D_md_use     (D_md_use),
        .E_md_start   (E_md_start),
        .E_md_is_div  (E_md_is_div),
        .stall        (stall),
        .md_busy      (md_busy),
        .md_cnt       (md_cnt),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        Tuse_rs     = 2'd2;
        Tuse_rt     = 2'd2;
        D_rs_addr   = '0;
        D_rt_addr   = '0;
        E_RFDst     = '0;
        Tnew_E      = '0;
        M_RFDst     = '0;
        Tnew_M      = '0;
        D_md_use    = 1'b0;
        E_md_start  = 1'b0;
        E_md_is_div = 1'b0;
    endtask

    task automatic check_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty got 0 entries required 1");
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            assert (stall === e.stall) else begin
                n_fail++;
                $error("FAIL %s.stall got %0b required %0b",
                       e.tag, stall, e.stall);
            end
            n_tests++;
            assert (md_cnt === e.cnt) else begin
                n_fail++;
                $error("FAIL %s.md_cnt got %0d required %0d",
                       e.tag, md_cnt, e.cnt);
            end
            n_tests++;
            assert (md_busy === e.busy) else begin
                n_fail++;
                $error("FAIL %s.md_busy got %0b required %0b",
                       e.tag, md_busy, e.busy);
            end
            n_tests++;
            assert (stall_cycles === e.sc) else begin
                n_fail++;
                $error("FAIL %s.stall_cycles got %0d required %0d",
                       e.tag, stall_cycles, e.sc);
            end
        end
    endtask

    // Inputs are already applied; one cycle is checked then clocked.
    task automatic step(input string tag, input logic s,
                        input int cnt);
        exp_t e;
        e.tag   = tag;
        e.stall = s;
        e.cnt   = CW'(cnt);
        e.busy  = (cnt != 0);
        e.sc    = PW'(sc_model);
        exp_q.push_back(e);
        @(negedge clk);
        check_front();
        @(posedge clk);
        if (reset) sc_model = 0;
        else if (s && sc_model < (1 << PW) - 1) sc_model++;
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        sc_model = 0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 1'b0, 0);
        reset = 1'b0;

        Tuse_rs = 2'd0; D_rs_addr = 5'd8;
        E_RFDst = 5'd8; Tnew_E = 2'd1;
        step("rs_e_hazard", 1'b1, 0);
        D_rs_addr = 5'd0; E_RFDst = 5'd0;
        step("rs_zero_reg", 1'b0, 0);
        Tuse_rs = 2'd1; D_rs_addr = 5'd3;
        E_RFDst = 5'd3; Tnew_E = 2'd1;
        step("rs_e_equal_t", 1'b0, 0);
        idle_inputs();

        Tuse_rt = 2'd1; D_rt_addr = 5'd9;
        M_RFDst = 5'd9; Tnew_M = 2'd1;
        step("rt_m_ge", 1'b0, 0);
        Tuse_rt = 2'd0;
        step("rt_m_lt", 1'b1, 0);
        Tuse_rt = 2'd1; Tnew_M = 2'd0;
        D_rt_addr = 5'd4; E_RFDst = 5'd4; Tnew_E = 2'd2;
        step("rt_e_t1_t2", 1'b1, 0);
        idle_inputs();

        D_md_use = 1'b1;
        E_md_start = 1'b1;
        step("mult_start", 1'b1, 0);
        E_md_start = 1'b0;
        for (int i = 5; i >= 1; i--) step("mult_busy", 1'b1, i);
        step("mult_done", 1'b0, 0);
        idle_inputs();

        E_md_start = 1'b1; E_md_is_div = 1'b1;
        step("div_start", 1'b0, 0);
        E_md_start = 1'b0; E_md_is_div = 1'b0;
        step("div_busy1", 1'b0, 10);
        step("div_busy2", 1'b0, 9);
        reset = 1'b1;
        step("div_reset", 1'b0, 8);
        reset = 1'b0;
        D_md_use = 1'b1;
        step("div_aborted", 1'b0, 0);
        idle_inputs();

        D_md_use = 1'b1; E_md_start = 1'b1;
        Tuse_rs = 2'd0; D_rs_addr = 5'd5;
        E_RFDst = 5'd5; Tnew_E = 2'd1;
        step("both_start", 1'b1, 0);
        E_md_start = 1'b0;
        step("both_busy", 1'b1, 5);
        D_rs_addr = 5'd0; E_RFDst = 5'd0;
        for (int i = 4; i >= 1; i--) step("md_only", 1'b1, i);
        step("both_clear", 1'b0, 0);
        idle_inputs();

        reset = 1'b1;
        step("sat_pre_reset", 1'b0, 0);
        reset = 1'b0;
        Tuse_rs = 2'd0; D_rs_addr = 5'd7;
        E_RFDst = 5'd7; Tnew_E = 2'd2;
        for (int i = 0; i < 20; i++) step("sat_hold", 1'b1, 0);
        @(negedge clk);
        n_tests++;
        assert (stall_cycles === 4'hF) else begin
            n_fail++;
            $error("FAIL sat_value got %0d required 15", stall_cycles);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        step("sat_hold_idle", 1'b0, 0);
        reset = 1'b1;
        step("sat_reset", 1'b0, 0);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        assert (stall_cycles === 4'h0) else begin
            n_fail++;
            $error("FAIL sat_cleared got %0d required 0", stall_cycles);
        end
        step("final", 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
